branch_resolve_unit: RTL and testbench

//  EX-stage branch resolution. Checks the BPU prediction that travels with each

---
 rtl/branch_resolve_unit_if.sv | 39 +++
 rtl/branch_resolve_unit.sv | 147 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch resolution bus: EX operands and pipeline control in,
// BPU update, fetch redirect and statistics out.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             flush_in;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic [32:0]      ex_pred_info;
  logic             ds_valid;
  logic [65:0]      ex_branch_info;
  logic             pred_flag;
  logic             pred_true;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_out;
  logic             busy;
  logic [CNT_W-1:0] stat_br_cnt;
  logic [CNT_W-1:0] stat_miss_cnt;

  modport master (
    output stall, flush_in, ex_valid, ex_is_branch, ex_is_jump, ex_pc,
           ex_taken, ex_target, ex_pred_info, ds_valid,
    input  ex_branch_info, pred_flag, pred_true, redirect_valid,
           redirect_pc, flush_out, busy, stat_br_cnt, stat_miss_cnt
  );

  modport slave (
    input  stall, flush_in, ex_valid, ex_is_branch, ex_is_jump, ex_pc,
           ex_taken, ex_target, ex_pred_info, ds_valid,
    output ex_branch_info, pred_flag, pred_true, redirect_valid,
           redirect_pc, flush_out, busy, stat_br_cnt, stat_miss_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: compares the IF prediction with the real outcome,
// feeds the BPU update port, redirects fetch after the delay slot, keeps stats.
module branch_resolve_unit #(
  parameter logic [31:0] DS_OFFSET = 32'd8,
  parameter int          CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  branch_resolve_unit_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_DS = 2'd1;
  localparam logic [1:0] REDIR   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [65:0]      info_q, info_d;
  logic             pred_flag_q, pred_flag_d;
  logic             pred_true_q, pred_true_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             pred_taken_s;
  logic [31:0]      pred_target_s;
  logic             resolve_s;
  logic             miss_s;
  logic [31:0]      correct_pc_s;

  // Prediction check for the instruction currently in EX
  always_comb begin
    pred_taken_s  = bus.ex_pred_info[32];
    pred_target_s = bus.ex_pred_info[31:0];
    resolve_s     = bus.ex_valid & (bus.ex_is_branch | bus.ex_is_jump) &
                    (state_q == IDLE) & ~bus.stall & ~bus.flush_in;
    miss_s        = (pred_taken_s != bus.ex_taken) |
                    (pred_taken_s & bus.ex_taken & (pred_target_s != bus.ex_target));
    correct_pc_s  = bus.ex_taken ? bus.ex_target : (bus.ex_pc + DS_OFFSET);
  end

  // Redirect FSM; flush_in beats stall, stall freezes everything else
  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    if (bus.flush_in) begin
      state_d = IDLE;
    end else if (bus.stall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (resolve_s && miss_s) begin
            state_d    = bus.ds_valid ? REDIR : WAIT_DS;
            redir_pc_d = correct_pc_s;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_DS: begin
          if (bus.ds_valid) begin
            state_d = REDIR;
          end else begin
            state_d = WAIT_DS;
          end
        end
        REDIR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // BPU update port: one-cycle pulse after resolve, held while stalled
  always_comb begin
    info_d      = 66'd0;
    pred_flag_d = 1'b0;
    pred_true_d = 1'b0;
    if (bus.flush_in) begin
      info_d      = 66'd0;
      pred_flag_d = 1'b0;
      pred_true_d = 1'b0;
    end else if (bus.stall) begin
      info_d      = info_q;
      pred_flag_d = pred_flag_q;
      pred_true_d = pred_true_q;
    end else if (resolve_s) begin
      info_d      = {bus.ex_taken, bus.ex_target, bus.ex_is_branch, bus.ex_pc};
      pred_flag_d = miss_s;
      pred_true_d = ~miss_s;
    end else begin
      info_d      = 66'd0;
      pred_flag_d = 1'b0;
      pred_true_d = 1'b0;
    end
  end

  // Saturating statistics
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (resolve_s && (br_cnt_q != CNT_MAX)) begin
      br_cnt_d = br_cnt_q + CNT_ONE;
    end else begin
      br_cnt_d = br_cnt_q;
    end
    if (resolve_s && miss_s && (miss_cnt_q != CNT_MAX)) begin
      miss_cnt_d = miss_cnt_q + CNT_ONE;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      info_q      <= 66'd0;
      pred_flag_q <= 1'b0;
      pred_true_q <= 1'b0;
      redir_pc_q  <= 32'd0;
      br_cnt_q    <= {CNT_W{1'b0}};
      miss_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      info_q      <= info_d;
      pred_flag_q <= pred_flag_d;
      pred_true_q <= pred_true_d;
      redir_pc_q  <= redir_pc_d;
      br_cnt_q    <= br_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // The redirect is gated by the live stall so a stalled REDIR cycle never fires
  assign bus.redirect_valid = (state_q == REDIR) & ~bus.stall & ~bus.flush_in;
  assign bus.flush_out      = (state_q == REDIR) & ~bus.stall & ~bus.flush_in;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.ex_branch_info = info_q;
  assign bus.pred_flag      = pred_flag_q;
  assign bus.pred_true      = pred_true_q;
  assign bus.stat_br_cnt    = br_cnt_q;
  assign bus.stat_miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; counters are narrowed to 4 bits
// so saturation is reachable in a short run.
module tb_branch_resolve_unit;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  logic [3:0] exp_br;
  logic [3:0] exp_miss;

  branch_resolve_unit_if #(.CNT_W(4)) bus ();

  branch_resolve_unit #(.DS_OFFSET(32'd8), .CNT_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall        = 1'b0;
    bus.flush_in     = 1'b0;
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_is_jump   = 1'b0;
    bus.ex_pc        = 32'd0;
    bus.ex_taken     = 1'b0;
    bus.ex_target    = 32'd0;
    bus.ex_pred_info = 33'd0;
    bus.ds_valid     = 1'b0;
  endtask

  task automatic set_branch(input logic jump, input logic [31:0] pc, input logic taken,
                            input logic [31:0] tgt, input logic [32:0] pred, input logic ds);
    bus.ex_valid     = 1'b1;
    bus.ex_is_branch = ~jump;
    bus.ex_is_jump   = jump;
    bus.ex_pc        = pc;
    bus.ex_taken     = taken;
    bus.ex_target    = tgt;
    bus.ex_pred_info = pred;
    bus.ds_valid     = ds;
  endtask

  task automatic bump(input logic miss);
    if (exp_br != 4'hF) exp_br = exp_br + 4'd1;
    if (miss && exp_miss != 4'hF) exp_miss = exp_miss + 4'd1;
  endtask

  task automatic check_counts(input string name);
    checks++;
    if (bus.stat_br_cnt !== exp_br || bus.stat_miss_cnt !== exp_miss) begin
      errors++;
      $display("FAIL %s_counts: got br=%0d miss=%0d exp br=%0d miss=%0d", name,
               bus.stat_br_cnt, bus.stat_miss_cnt, exp_br, exp_miss);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    #2;
    checks++;
    if ({bus.busy, bus.redirect_valid, bus.flush_out, bus.pred_flag, bus.pred_true} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 00000",
               {bus.busy, bus.redirect_valid, bus.flush_out, bus.pred_flag, bus.pred_true});
    end
    checks++;
    if (bus.ex_branch_info !== 66'd0 || bus.redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got info=%h pc=%h exp 0", bus.ex_branch_info, bus.redirect_pc);
    end
    check_counts("reset");
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_correct_pred();
    set_branch(1'b0, 32'h80000010, 1'b1, 32'h80000100, {1'b1, 32'h80000100}, 1'b1);
    tick();
    clear_inputs();
    bump(1'b0);
    checks++;
    if (bus.pred_true !== 1'b1 || bus.pred_flag !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_pulse: got true=%b flag=%b rv=%b exp 1 0 0",
               bus.pred_true, bus.pred_flag, bus.redirect_valid);
    end
    checks++;
    if (bus.ex_branch_info !== {1'b1, 32'h80000100, 1'b1, 32'h80000010}) begin
      errors++;
      $display("FAIL t1_info: got %h exp %h", bus.ex_branch_info,
               {1'b1, 32'h80000100, 1'b1, 32'h80000010});
    end
    check_counts("t1");
    tick();
    checks++;
    if (bus.ex_branch_info !== 66'd0 || bus.pred_true !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_after: got info=%h true=%b busy=%b exp 0", bus.ex_branch_info,
               bus.pred_true, bus.busy);
    end
  endtask

  task automatic test_mispredict_ds();
    set_branch(1'b0, 32'h80000020, 1'b1, 32'h80000200, 33'd0, 1'b1);
    tick();
    clear_inputs();
    bump(1'b1);
    checks++;
    if (bus.pred_flag !== 1'b1 || bus.pred_true !== 1'b0 || bus.redirect_valid !== 1'b1 ||
        bus.flush_out !== 1'b1) begin
      errors++;
      $display("FAIL t2_pulse: got flag=%b true=%b rv=%b fo=%b exp 1 0 1 1",
               bus.pred_flag, bus.pred_true, bus.redirect_valid, bus.flush_out);
    end
    checks++;
    if (bus.redirect_pc !== 32'h80000200) begin
      errors++;
      $display("FAIL t2_pc: got %h exp 80000200", bus.redirect_pc);
    end
    check_counts("t2");
    tick();
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pred_flag !== 1'b0) begin
      errors++;
      $display("FAIL t2_after: got rv=%b busy=%b flag=%b exp 0 0 0",
               bus.redirect_valid, bus.busy, bus.pred_flag);
    end
  endtask

  task automatic test_wait_ds();
    set_branch(1'b1, 32'h00000400, 1'b1, 32'h00002000, {1'b1, 32'h00001000}, 1'b0);
    tick();
    clear_inputs();
    bump(1'b1);
    checks++;
    if (bus.ex_branch_info !== {1'b1, 32'h00002000, 1'b0, 32'h00000400} || bus.pred_flag !== 1'b1) begin
      errors++;
      $display("FAIL t3_info: got %h flag=%b exp %h 1", bus.ex_branch_info, bus.pred_flag,
               {1'b1, 32'h00002000, 1'b0, 32'h00000400});
    end
    // wrong-path branch while waiting must be ignored
    set_branch(1'b0, 32'h00000408, 1'b1, 32'h00000500, 33'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.redirect_valid !== 1'b0 || bus.pred_flag !== 1'b0) begin
        errors++;
        $display("FAIL t3_wait%0d: got busy=%b rv=%b flag=%b exp 1 0 0", i, bus.busy,
                 bus.redirect_valid, bus.pred_flag);
      end
    end
    clear_inputs();
    check_counts("t3_wait");
    bus.ds_valid = 1'b1;
    tick();
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h00002000) begin
      errors++;
      $display("FAIL t3_redir: got rv=%b pc=%h exp 1 00002000", bus.redirect_valid, bus.redirect_pc);
    end
    bus.ds_valid = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL t3_after: got busy=%b rv=%b exp 0 0", bus.busy, bus.redirect_valid);
    end
  endtask

  task automatic test_wrap();
    set_branch(1'b0, 32'hFFFFFFFC, 1'b0, 32'h00000100, {1'b1, 32'h00000100}, 1'b1);
    tick();
    clear_inputs();
    bump(1'b1);
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h00000004 || bus.pred_flag !== 1'b1) begin
      errors++;
      $display("FAIL t4_wrap: got rv=%b pc=%h flag=%b exp 1 00000004 1", bus.redirect_valid,
               bus.redirect_pc, bus.pred_flag);
    end
    check_counts("t4");
    tick();
  endtask

  task automatic test_flush();
    set_branch(1'b0, 32'h80000030, 1'b0, 32'h80000400, {1'b1, 32'h80000400}, 1'b0);
    tick();
    clear_inputs();
    bump(1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL t5_wait: got busy=%b exp 1", bus.busy);
    end
    bus.flush_in = 1'b1;
    bus.ds_valid = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.flush_out !== 1'b0) begin
        errors++;
        $display("FAIL t5_idle%0d: got busy=%b rv=%b fo=%b exp 0 0 0", i, bus.busy,
                 bus.redirect_valid, bus.flush_out);
      end
      tick();
    end
    check_counts("t5");
    set_branch(1'b0, 32'h80000040, 1'b1, 32'h80000500, 33'd0, 1'b1);
    bus.flush_in = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.pred_flag !== 1'b0 || bus.pred_true !== 1'b0 || bus.ex_branch_info !== 66'd0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_same_cycle: got flag=%b true=%b info=%h busy=%b exp 0", bus.pred_flag,
               bus.pred_true, bus.ex_branch_info, bus.busy);
    end
    check_counts("t5_same_cycle");
  endtask

  task automatic test_stall();
    set_branch(1'b0, 32'h80000050, 1'b1, 32'h80000300, 33'd0, 1'b1);
    tick();
    clear_inputs();
    bump(1'b1);
    bus.stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.redirect_valid !== 1'b0 || bus.flush_out !== 1'b0 || bus.busy !== 1'b1 ||
          bus.pred_flag !== 1'b1) begin
        errors++;
        $display("FAIL t6_stall%0d: got rv=%b fo=%b busy=%b flag=%b exp 0 0 1 1", i,
                 bus.redirect_valid, bus.flush_out, bus.busy, bus.pred_flag);
      end
      if (i < 2) tick();
    end
    bus.stall = 1'b0;
    #1;
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.flush_out !== 1'b1 || bus.redirect_pc !== 32'h80000300) begin
      errors++;
      $display("FAIL t6_release: got rv=%b fo=%b pc=%h exp 1 1 80000300", bus.redirect_valid,
               bus.flush_out, bus.redirect_pc);
    end
    tick();
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pred_flag !== 1'b0) begin
      errors++;
      $display("FAIL t6_after: got rv=%b busy=%b flag=%b exp 0 0 0", bus.redirect_valid,
               bus.busy, bus.pred_flag);
    end
    check_counts("t6");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      set_branch(1'b0, 32'h00001000 + 32'(i * 4), i[0], 32'h00005000 + 32'(i * 16),
                 {i[0], 32'h00005000 + 32'(i * 16)}, 1'b1);
      tick();
      bump(1'b0);
      checks++;
      if (bus.pred_true !== 1'b1 || bus.ex_branch_info[31:0] !== 32'h00001000 + 32'(i * 4)) begin
        errors++;
        $display("FAIL b2b_%0d: got true=%b pc=%h exp 1 %h", i, bus.pred_true,
                 bus.ex_branch_info[31:0], 32'h00001000 + 32'(i * 4));
      end
    end
    clear_inputs();
    tick();
    check_counts("b2b");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 11; i++) begin
      set_branch(1'b1, 32'h00000800, 1'b1, 32'h00003000, {1'b1, 32'h00003004}, 1'b1);
      tick();
      clear_inputs();
      bump(1'b1);
      checks++;
      if (bus.pred_flag !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.stat_miss_cnt !== exp_miss) begin
        errors++;
        $display("FAIL sat_%0d: got flag=%b rv=%b miss=%0d exp 1 1 %0d", i, bus.pred_flag,
                 bus.redirect_valid, bus.stat_miss_cnt, exp_miss);
      end
      tick();
    end
    checks++;
    if (bus.stat_br_cnt !== 4'hF || bus.stat_miss_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_final: got br=%h miss=%h exp F F", bus.stat_br_cnt, bus.stat_miss_cnt);
    end
  endtask

  task automatic test_async_reset();
    set_branch(1'b0, 32'h80000060, 1'b1, 32'h80000600, 33'd0, 1'b0);
    tick();
    clear_inputs();
    #2;
    resetn = 1'b0;
    #1;
    exp_br   = 4'd0;
    exp_miss = 4'd0;
    checks++;
    if (bus.busy !== 1'b0 || bus.pred_flag !== 1'b0 || bus.ex_branch_info !== 66'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b flag=%b info=%h exp 0", bus.busy, bus.pred_flag,
               bus.ex_branch_info);
    end
    check_counts("async_reset");
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_br   = 4'd0;
    exp_miss = 4'd0;
    test_reset();
    test_correct_pred();
    test_mispredict_ds();
    test_wait_ds();
    test_wrap();
    test_flush();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
